mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one single-port memory slave between the OpenMIPS instruction-fetch port (m0, read-only) and data-access port (m1, read/write) in the min SOPC. Arbitrates round-robin, registers a single outstanding slave transaction, and returns per-port ack/err with read data. Emits per-port stall requests to the pipeline ctrl block. A bounded timeout guarantees forward progress if the slave never acks.

Parameters:
ADDR_W, 32, address width for both masters and the slave
DATA_W, 32, data width; byte-select width is DATA_W/8
TIMEOUT, 16, slave cycles to wait for s_ack before an error completion (minimum 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high (1 = RstEnable)
m0_req  in  1  instruction port request; held until m0_ack or m0_err
m0_addr  in  ADDR_W  instruction fetch address
m0_rdata  out  DATA_W  fetched word; valid while m0_ack=1
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  one-cycle timeout completion pulse
m1_req  in  1  data port request; held until m1_ack or m1_err
m1_we  in  1  1 = write, 0 = read
m1_addr  in  ADDR_W  data address
m1_wdata  in  DATA_W  write data
m1_sel  in  DATA_W/8  byte enables
m1_rdata  out  DATA_W  read data; valid while m1_ack=1
m1_ack  out  1  one-cycle completion pulse
m1_err  out  1  one-cycle timeout completion pulse
s_cyc  out  1  slave transaction active
s_we  out  1  slave write enable
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_sel  out  DATA_W/8  slave byte enables (4'b1111 for m0)
s_rdata  in  DATA_W  slave read data, valid with s_ack
s_ack  in  1  slave completion, one cycle
stallreq_if  out  1  m0_req & ~(m0_ack|m0_err)
stallreq_mem  out  1  m1_req & ~(m1_ack|m1_err)

Behaviour:
- Reset (async, immediate): state=IDLE, last_grant=m0, timeout counter=0; all registered outputs 0 (s_cyc, s_we, s_addr, s_wdata, s_sel, m*_ack, m*_err, m*_rdata). stallreq_* are combinational and follow their equations.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: if only m0_req -> latch m0 into s_* (s_we=0, s_sel all ones), s_cyc=1, go BUSY_I. If only m1_req -> latch m1, go BUSY_D. If both -> grant the port that is not last_grant; after reset, m1 wins. Set last_grant on every grant.
- BUSY_x: s_* outputs are held stable. On s_ack: capture s_rdata into mx_rdata, pulse mx_ack for 1 cycle, s_cyc=0, counter=0, go IDLE. If counter reaches TIMEOUT-1 without s_ack: pulse mx_err, mx_rdata=0, s_cyc=0, go IDLE.
- Latency: request seen in IDLE at cycle N -> s_cyc=1 at N+1; s_ack at cycle K -> mx_ack at K+1. Zero-wait slave gives 3 cycles from req to ack. One mandatory IDLE cycle between transactions.
- mx_ack/mx_err are never asserted together or for more than one cycle. At most one port completes per cycle.
- Master drops req mid-transaction (abort): the slave cycle still runs to s_ack or timeout. The completion pulse is suppressed if req=0 in the completion cycle; no restart.
- s_ack while in IDLE: ignored.
- s_ack in the same cycle the counter hits TIMEOUT-1: ack wins, no err.
- Counter width is clog2(TIMEOUT). It saturates and never wraps.
- m1 write: mx_rdata is captured from s_rdata regardless, and the master ignores it.

Decomposition:
- Shared defines (existing defines.v): RstEnable/RstDisable, state encodings ARB_IDLE/ARB_BUSY_I/ARB_BUSY_D, Stop/NoStop stall levels.
- One natural sub-module, rr_arb2: a 2-way round-robin grant with a last_grant register. The FSM, timeout counter and slave muxing stay in the top level.

Test Plan:
- Reset mid-BUSY_D (rst=1 while s_cyc=1) -> s_cyc=0 in the same delta; after release, state=IDLE and all outputs are 0.
- m0_req only, addr=0x0000_0004, slave acks 1 cycle after s_cyc with 0x3401_1100 -> s_sel=4'hF, s_we=0, m0_ack pulse with m0_rdata=0x3401_1100, stallreq_if high until the ack cycle.
- m0 and m1 both requesting continuously from reset -> grants alternate m1,m0,m1,m0; m1 write addr=0x10, wdata=0xDEAD_BEEF, sel=4'b0011 appears exactly on s_*.
- Slave never acks, TIMEOUT=16 -> m1_err pulses exactly 16 cycles after s_cyc rises, m1_rdata=0, then m0 is granted next.
- s_ack arrives in the timeout cycle -> only m0_ack pulses, m0_err stays 0.
- m0 drops req while BUSY_I, slave acks 3 cycles later -> no m0_ack, the arbiter returns to IDLE and serves the pending m1.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant; remembers which port was served last.
module mem_bus_arbiter_rr_arb2
  import mem_bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic take_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // 0 = port 0 served last, 1 = port 1 served last
  logic last_q;

  // On contention, the port not served last wins
  always_comb begin
    gnt1_o = req1_i & (~req0_i | ~last_q);
    gnt0_o = req0_i & (~req1_i |  last_q);
  end

  // Record the winner whenever a grant is actually taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      last_q <= 1'b0;
    end else if (take_i && (gnt0_o || gnt1_o)) begin
      last_q <= gnt1_o;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory slave between the instruction-fetch port (m0)
// and the data port (m1), one registered transaction at a time, with timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ack,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ack,
  output logic                m1_err,
  output logic                s_cyc,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ack,
  output logic                stallreq_if,
  output logic                stallreq_mem
);

  localparam int             CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                s_cyc_q, s_we_q;
  logic [ADDR_W-1:0]   s_addr_q;
  logic [DATA_W-1:0]   s_wdata_q;
  logic [DATA_W/8-1:0] s_sel_q;
  logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;
  logic                m0_ack_q, m0_err_q, m1_ack_q, m1_err_q;
  logic                m0_pend, m1_pend;
  logic                gnt0, gnt1;

  // A port whose completion is showing this cycle is not re-granted
  assign m0_pend = m0_req & ~(m0_ack_q | m0_err_q);
  assign m1_pend = m1_req & ~(m1_ack_q | m1_err_q);

  assign stallreq_if  = m0_pend ? Stop : NoStop;
  assign stallreq_mem = m1_pend ? Stop : NoStop;

  mem_bus_arbiter_rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req0_i (m0_pend),
    .req1_i (m1_pend),
    .take_i (state_q == ARB_IDLE),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  // Saturating wait counter; the timeout branch stops it at CNT_MAX
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // Arbiter FSM with registered slave-side and master-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      s_cyc_q    <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_sel_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      m0_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m1_err_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          cnt_q <= '0;
          if (gnt1) begin
            state_q   <= ARB_BUSY_D;
            s_cyc_q   <= 1'b1;
            s_we_q    <= m1_we;
            s_addr_q  <= m1_addr;
            s_wdata_q <= m1_wdata;
            s_sel_q   <= m1_sel;
          end else if (gnt0) begin
            state_q   <= ARB_BUSY_I;
            s_cyc_q   <= 1'b1;
            s_we_q    <= 1'b0;
            s_addr_q  <= m0_addr;
            s_wdata_q <= '0;
            s_sel_q   <= '1;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (s_ack) begin
            state_q <= ARB_IDLE;
            s_cyc_q <= 1'b0;
            cnt_q   <= '0;
            // An aborted master (req dropped) gets no completion pulse
            if (state_q == ARB_BUSY_I) begin
              m0_rdata_q <= s_rdata;
              m0_ack_q   <= m0_req;
            end else begin
              m1_rdata_q <= s_rdata;
              m1_ack_q   <= m1_req;
            end
          end else if (cnt_q == CNT_MAX) begin
            state_q <= ARB_IDLE;
            s_cyc_q <= 1'b0;
            cnt_q   <= '0;
            if (state_q == ARB_BUSY_I) begin
              m0_rdata_q <= '0;
              m0_err_q   <= m0_req;
            end else begin
              m1_rdata_q <= '0;
              m1_err_q   <= m1_req;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          s_cyc_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign s_cyc    = s_cyc_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_sel    = s_sel_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_ack   = m0_ack_q;
  assign m0_err   = m0_err_q;
  assign m1_ack   = m1_ack_q;
  assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, single read, round robin,
// timeout, ack-at-timeout and abort scenarios.
module tb_mem_bus_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m0_req = 1'b0;
  logic [31:0]       m0_addr = '0;
  logic [31:0]       m0_rdata;
  logic              m0_ack, m0_err;
  logic              m1_req = 1'b0;
  logic              m1_we = 1'b0;
  logic [31:0]       m1_addr = '0;
  logic [31:0]       m1_wdata = '0;
  logic [3:0]        m1_sel = '0;
  logic [31:0]       m1_rdata;
  logic              m1_ack, m1_err;
  logic              s_cyc, s_we;
  logic [31:0]       s_addr, s_wdata;
  logic [3:0]        s_sel;
  logic [31:0]       s_rdata = '0;
  logic              s_ack = 1'b0;
  logic              stallreq_if, stallreq_mem;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for s_cyc to rise; an expired bound is a miscompare
  task automatic wait_cyc(input string tag);
    int n = 0;
    while (!s_cyc && n < 6) begin
      tick();
      n++;
    end
    vectors++;
    if (s_cyc !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_wait_cyc s_cyc=%0b after %0d cycles, want 1", tag, s_cyc, n);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({s_cyc, s_we, s_addr, s_wdata, s_sel} !== '0) begin
      miscompares++;
      $display("FAIL reset_slave got cyc=%0b we=%0b addr=%h wdata=%h sel=%h want all 0", s_cyc, s_we, s_addr, s_wdata, s_sel);
    end
    vectors++;
    if ({m0_ack, m0_err, m1_ack, m1_err, m0_rdata, m1_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_master got acks/errs=%b%b%b%b r0=%h r1=%h want 0", m0_ack, m0_err, m1_ack, m1_err, m0_rdata, m1_rdata);
    end
    vectors++;
    if ({stallreq_if, stallreq_mem} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_stall got %b%b want 00", stallreq_if, stallreq_mem);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h1234_5678; m1_sel = 4'hF;
    tick();
    vectors++;
    if (s_cyc !== 1'b1 || s_we !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_grant got cyc=%0b we=%0b want 1 1", s_cyc, s_we);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (s_cyc !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async got s_cyc=%0b want 0", s_cyc);
    end
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_sel = '0;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({s_cyc, s_we, s_addr, s_wdata, s_sel, m0_ack, m0_err, m1_ack, m1_err, m0_rdata, m1_rdata} !== '0) begin
      miscompares++;
      $display("FAIL midrst_release got cyc=%0b we=%0b addr=%h wdata=%h sel=%h want all 0", s_cyc, s_we, s_addr, s_wdata, s_sel);
    end
  endtask

  task automatic test_m0_read();
    m0_req = 1'b1; m0_addr = 32'h0000_0004;
    #1;
    vectors++;
    if (stallreq_if !== 1'b1) begin
      miscompares++;
      $display("FAIL m0rd_stall_pre got %0b want 1", stallreq_if);
    end
    tick();
    vectors++;
    if (s_cyc !== 1'b1 || s_we !== 1'b0 || s_sel !== 4'hF || s_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL m0rd_slave got cyc=%0b we=%0b sel=%h addr=%h want 1 0 f 00000004", s_cyc, s_we, s_sel, s_addr);
    end
    tick();
    vectors++;
    if (stallreq_if !== 1'b1 || m0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL m0rd_wait got stall=%0b ack=%0b want 1 0", stallreq_if, m0_ack);
    end
    s_ack = 1'b1; s_rdata = 32'h3401_1100;
    tick();
    s_ack = 1'b0; s_rdata = '0;
    vectors++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'h3401_1100 || m0_err !== 1'b0) begin
      miscompares++;
      $display("FAIL m0rd_ack got ack=%0b err=%0b rdata=%h want 1 0 34011100", m0_ack, m0_err, m0_rdata);
    end
    vectors++;
    if (stallreq_if !== 1'b0 || s_cyc !== 1'b0) begin
      miscompares++;
      $display("FAIL m0rd_done got stall=%0b cyc=%0b want 0 0", stallreq_if, s_cyc);
    end
    m0_req = 1'b0;
    tick();
    vectors++;
    if (m0_ack !== 1'b0 || s_cyc !== 1'b0) begin
      miscompares++;
      $display("FAIL m0rd_pulse got ack=%0b cyc=%0b want 0 0", m0_ack, s_cyc);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'hDEAD_BEEF; m1_sel = 4'b0011;
    for (int g = 0; g < 4; g++) begin
      logic exp_m1;
      exp_m1 = (g % 2) == 0;
      wait_cyc("rr");
      vectors++;
      if (exp_m1) begin
        if (s_we !== 1'b1 || s_addr !== 32'h10 || s_wdata !== 32'hDEAD_BEEF || s_sel !== 4'b0011) begin
          miscompares++;
          $display("FAIL rr_grant%0d_m1 got we=%0b addr=%h wdata=%h sel=%h want 1 00000010 deadbeef 3", g, s_we, s_addr, s_wdata, s_sel);
        end
      end else begin
        if (s_we !== 1'b0 || s_addr !== 32'h100 || s_sel !== 4'hF) begin
          miscompares++;
          $display("FAIL rr_grant%0d_m0 got we=%0b addr=%h sel=%h want 0 00000100 f", g, s_we, s_addr, s_sel);
        end
      end
      s_ack = 1'b1; s_rdata = 32'h1000_0000 + g;
      tick();
      s_ack = 1'b0;
      vectors++;
      if (m1_ack !== exp_m1 || m0_ack !== !exp_m1) begin
        miscompares++;
        $display("FAIL rr_ack%0d got m0_ack=%0b m1_ack=%0b want %0b %0b", g, m0_ack, m1_ack, !exp_m1, exp_m1);
      end
      vectors++;
      if ((exp_m1 ? m1_rdata : m0_rdata) !== 32'h1000_0000 + g) begin
        miscompares++;
        $display("FAIL rr_rdata%0d got %h want %h", g, exp_m1 ? m1_rdata : m0_rdata, 32'h1000_0000 + g);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0; m1_sel = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_sel = 4'hF;
    m0_req = 1'b1; m0_addr = 32'h40;
    wait_cyc("to");
    vectors++;
    if (s_addr !== 32'h20 || s_we !== 1'b0) begin
      miscompares++;
      $display("FAIL to_grant got addr=%h we=%0b want 00000020 0", s_addr, s_we);
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (k == TIMEOUT - 1) begin
        vectors++;
        if (m1_err !== 1'b0 || s_cyc !== 1'b1) begin
          miscompares++;
          $display("FAIL to_early got err=%0b cyc=%0b at %0d want 0 1", m1_err, s_cyc, k);
        end
      end
    end
    vectors++;
    if (m1_err !== 1'b1 || m1_ack !== 1'b0 || m1_rdata !== 32'h0 || s_cyc !== 1'b0) begin
      miscompares++;
      $display("FAIL to_err got err=%0b ack=%0b rdata=%h cyc=%0b want 1 0 00000000 0", m1_err, m1_ack, m1_rdata, s_cyc);
    end
    tick();
    vectors++;
    if (m1_err !== 1'b0 || s_cyc !== 1'b1 || s_addr !== 32'h40 || s_we !== 1'b0) begin
      miscompares++;
      $display("FAIL to_next got err=%0b cyc=%0b addr=%h we=%0b want 0 1 00000040 0", m1_err, s_cyc, s_addr, s_we);
    end
  endtask

  // Continues the m0 transaction granted at the end of test_timeout
  task automatic test_ack_at_timeout();
    m1_req = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
    end
    vectors++;
    if (m0_err !== 1'b0 || s_cyc !== 1'b1) begin
      miscompares++;
      $display("FAIL ackto_pre got err=%0b cyc=%0b want 0 1", m0_err, s_cyc);
    end
    s_ack = 1'b1; s_rdata = 32'hCAFE_0001;
    tick();
    s_ack = 1'b0;
    vectors++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hCAFE_0001) begin
      miscompares++;
      $display("FAIL ackto_win got ack=%0b err=%0b rdata=%h want 1 0 cafe0001", m0_ack, m0_err, m0_rdata);
    end
    m0_req = 1'b0;
    tick();
    vectors++;
    if (m0_err !== 1'b0 || m0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL ackto_after got ack=%0b err=%0b want 0 0", m0_ack, m0_err);
    end
  endtask

  task automatic test_abort();
    m0_req = 1'b1; m0_addr = 32'h80;
    tick();
    vectors++;
    if (s_cyc !== 1'b1 || s_addr !== 32'h80) begin
      miscompares++;
      $display("FAIL abort_grant got cyc=%0b addr=%h want 1 00000080", s_cyc, s_addr);
    end
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30; m1_sel = 4'hF;
    tick();
    tick();
    s_ack = 1'b1; s_rdata = 32'h5555_AAAA;
    tick();
    s_ack = 1'b0;
    vectors++;
    if (m0_ack !== 1'b0 || m0_err !== 1'b0 || s_cyc !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_noack got ack=%0b err=%0b cyc=%0b want 0 0 0", m0_ack, m0_err, s_cyc);
    end
    tick();
    vectors++;
    if (s_cyc !== 1'b1 || s_addr !== 32'h30 || s_we !== 1'b0 || stallreq_mem !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_m1 got cyc=%0b addr=%h we=%0b stall=%0b want 1 00000030 0 1", s_cyc, s_addr, s_we, stallreq_mem);
    end
    s_ack = 1'b1; s_rdata = 32'h0BAD_F00D;
    tick();
    s_ack = 1'b0;
    vectors++;
    if (m1_ack !== 1'b1 || m1_rdata !== 32'h0BAD_F00D || m0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_m1ack got m1_ack=%0b rdata=%h m0_ack=%0b want 1 0badf00d 0", m1_ack, m1_rdata, m0_ack);
    end
    m1_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_busy();
    test_m0_read();
    test_round_robin();
    test_timeout();
    test_ack_at_timeout();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
